trap_sequencer: RTL and testbench

// Machine-mode trap/return controller for the CSR datapath. Takes exception and interrupt

---
 rtl/trap_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry / MRET controller.
// Picks one exception or interrupt per instruction boundary, writes mepc,
// mcause and mtval through the CSR write port, and redirects fetch to mtvec.
// MRET restores MIE from MPIE and redirects fetch to mepc.
// Build option: define TRAP_VECTORED_EN to honour mtvec vectored mode (mode 1)
// for interrupts; when it is undefined every trap goes to the mtvec base.
//
// Handshake: a request is taken only when insn_valid=1 and the sequencer is
// idle (busy=0 before the request); the accept cycle itself already raises
// busy combinationally. trap is a single-cycle strobe, and address is
// meaningful only while trap=1.
module trap_sequencer #(
    parameter int XLEN     = 32,
    parameter int IRQ_SYNC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            insn_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] insn_word,
    input  logic            exc_illegal,
    input  logic            exc_ebreak,
    input  logic            exc_ecall,
    input  logic            exc_misalign,
    input  logic [XLEN-1:0] bad_addr,
    input  logic            irq_sw,
    input  logic            irq_tm,
    input  logic            irq_ext,
    input  logic [2:0]      mie_bits,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            mret,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            mstatus_mie,
    output logic            mstatus_mpie,
    output logic            busy,
    output logic            trap,
    output logic [XLEN-1:0] address,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_EPC   = 3'd1;
    localparam logic [2:0] S_W_CAUSE = 3'd2;
    localparam logic [2:0] S_W_TVAL  = 3'd3;
    localparam logic [2:0] S_JUMP    = 3'd4;
    localparam logic [2:0] S_RET     = 3'd5;

    localparam logic [11:0] A_MEPC   = 12'h341;
    localparam logic [11:0] A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MTVAL  = 12'h343;

    logic [2:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] tgt_q;

    logic [2:0]      irq_raw;
    logic [2:0]      irq_use;
    logic [2:0]      irq_en;
    logic            exc_any;
    logic            irq_pend;
    logic            is_irq;
    logic            take_trap;
    logic            take_ret;
    logic [XLEN-1:0] cause_d;
    logic [XLEN-1:0] tval_d;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] tgt_trap;
    logic            unused_bits;

    // Interrupt lines ordered {ext, sw, tm}.
    assign irq_raw = {irq_ext, irq_sw, irq_tm};

    generate
        if (IRQ_SYNC != 0) begin : g_irq_sync
            logic [2:0] irq_q;
            // One register stage on the asynchronous interrupt lines.
            always_ff @(posedge clk) begin
                if (rst) irq_q <= 3'b000;
                else     irq_q <= irq_raw;
            end
            assign irq_use = irq_q;
        end else begin : g_irq_direct
            assign irq_use = irq_raw;
        end
    endgenerate

    // mie_bits is {MEIE, MTIE, MSIE}; gate each line by its own enable.
    assign irq_en   = {irq_use[2] & mie_bits[2], irq_use[1] & mie_bits[0], irq_use[0] & mie_bits[1]};
    assign exc_any  = exc_illegal | exc_ebreak | exc_ecall | exc_misalign;
    assign irq_pend = mstatus_mie & (|irq_en);

    assign take_trap = insn_valid & (state == S_IDLE) & (exc_any | irq_pend);
    assign take_ret  = insn_valid & (state == S_IDLE) & ~exc_any & ~irq_pend & mret;

    // Cause / trap-value selection in fixed priority order.
    always_comb begin
        cause_d = '0;
        tval_d  = '0;
        is_irq  = 1'b0;
        if (exc_illegal) begin
            cause_d[4:0] = 5'd2;
            tval_d       = insn_word;
        end else if (exc_ebreak) begin
            cause_d[4:0] = 5'd3;
            tval_d       = pc;
        end else if (exc_ecall) begin
            cause_d[4:0] = 5'd11;
        end else if (exc_misalign) begin
            cause_d[4:0] = 5'd4;
            tval_d       = bad_addr;
        end else if (irq_pend) begin
            is_irq          = 1'b1;
            cause_d[XLEN-1] = 1'b1;
            if (irq_en[2])      cause_d[4:0] = 5'd11;
            else if (irq_en[1]) cause_d[4:0] = 5'd3;
            else                cause_d[4:0] = 5'd7;
        end
    end

    assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Vectored mode applies to interrupts only; modes 2/3 fall back to direct.
    assign tgt_trap = (is_irq && (mtvec[1:0] == 2'b01))
                      ? base + {{(XLEN-7){1'b0}}, cause_d[4:0], 2'b00}
                      : base;
`else
    assign tgt_trap = base;
`endif

    // Mode bits and mepc[0] never reach the target in every build.
    assign unused_bits = ^{mtvec[1:0], mepc[0], is_irq};

    // Sequencer state, latched trap context and mstatus MIE/MPIE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc_q         <= '0;
            cause_q      <= '0;
            tval_q       <= '0;
            tgt_q        <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_trap) begin
                        state   <= S_W_EPC;
                        pc_q    <= pc;
                        cause_q <= cause_d;
                        tval_q  <= tval_d;
                        tgt_q   <= tgt_trap;
                    end else if (take_ret) begin
                        state <= S_RET;
                        tgt_q <= {mepc[XLEN-1:1], 1'b0};
                    end
                end
                S_W_EPC:   state <= S_W_CAUSE;
                S_W_CAUSE: state <= S_W_TVAL;
                S_W_TVAL:  state <= S_JUMP;
                S_JUMP: begin
                    state        <= S_IDLE;
                    mstatus_mpie <= mstatus_mie;
                    mstatus_mie  <= 1'b0;
                end
                S_RET: begin
                    state        <= S_IDLE;
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // CSR write port and redirect outputs decoded from the current state.
    always_comb begin
        csr_we    = 1'b0;
        csr_waddr = 12'h000;
        csr_wdata = '0;
        case (state)
            S_W_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = A_MEPC;
                csr_wdata = pc_q;
            end
            S_W_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = A_MCAUSE;
                csr_wdata = cause_q;
            end
            S_W_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = A_MTVAL;
                csr_wdata = tval_q;
            end
            default: begin
                csr_we    = 1'b0;
                csr_waddr = 12'h000;
                csr_wdata = '0;
            end
        endcase
    end

    assign trap      = (state == S_JUMP) || (state == S_RET);
    assign address   = trap ? tgt_q : '0;
    assign busy      = (state != S_IDLE) || take_trap || take_ret;
    assign dbg_state = state;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: reset, MRET, interrupt entry, exception
// entry, exception-vs-MRET priority, masked interrupt, back-to-back traps and
// reset in the middle of a sequence.
module tb_trap_sequencer;

    logic        clk;
    logic        rst;
    logic        insn_valid;
    logic [31:0] pc;
    logic [31:0] insn_word;
    logic        exc_illegal;
    logic        exc_ebreak;
    logic        exc_ecall;
    logic        exc_misalign;
    logic [31:0] bad_addr;
    logic        irq_sw;
    logic        irq_tm;
    logic        irq_ext;
    logic [2:0]  mie_bits;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mret;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        busy;
    logic        trap;
    logic [31:0] address;
    logic [2:0]  dbg_state;

    int n_checks;
    int n_fail;

    trap_sequencer #(.XLEN(32), .IRQ_SYNC(1)) dut (
        .clk(clk), .rst(rst), .insn_valid(insn_valid), .pc(pc), .insn_word(insn_word),
        .exc_illegal(exc_illegal), .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_misalign(exc_misalign), .bad_addr(bad_addr), .irq_sw(irq_sw), .irq_tm(irq_tm),
        .irq_ext(irq_ext), .mie_bits(mie_bits), .mtvec(mtvec), .mepc(mepc), .mret(mret),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .busy(busy), .trap(trap),
        .address(address), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        insn_valid = 0; pc = 0; insn_word = 0; exc_illegal = 0; exc_ebreak = 0;
        exc_ecall = 0; exc_misalign = 0; bad_addr = 0; irq_sw = 0; irq_tm = 0; irq_ext = 0;
        mie_bits = 0; mtvec = 0; mepc = 0; mret = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1;
        tick(); tick();
        n_checks++; if (csr_we !== 1'b0) begin n_fail++; $display("FAIL reset_csr_we got %0b want 0", csr_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap got %0b want 0", trap); end
        n_checks++; if (address !== 32'h0) begin n_fail++; $display("FAIL reset_address got %h want 0", address); end
        n_checks++; if (csr_waddr !== 12'h0) begin n_fail++; $display("FAIL reset_waddr got %h want 0", csr_waddr); end
        n_checks++; if (csr_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", csr_wdata); end
        n_checks++; if (mstatus_mie !== 1'b0) begin n_fail++; $display("FAIL reset_mie got %0b want 0", mstatus_mie); end
        n_checks++; if (mstatus_mpie !== 1'b1) begin n_fail++; $display("FAIL reset_mpie got %0b want 1", mstatus_mpie); end
        rst = 0;
        tick();
    endtask

    // MRET with mpie=1: redirect to mepc next cycle, MIE becomes 1.
    task automatic test_mret;
        mepc = 32'h0000_0205;
        mret = 1; insn_valid = 1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mret_accept_busy got %0b want 1", busy); end
        tick();
        insn_valid = 0; mret = 0;
        n_checks++; if (trap !== 1'b1) begin n_fail++; $display("FAIL mret_trap got %0b want 1", trap); end
        n_checks++; if (address !== 32'h0000_0204) begin n_fail++; $display("FAIL mret_address got %h want 00000204", address); end
        n_checks++; if (csr_we !== 1'b0) begin n_fail++; $display("FAIL mret_csr_we got %0b want 0", csr_we); end
        tick();
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL mret_trap_end got %0b want 0", trap); end
        n_checks++; if (mstatus_mie !== 1'b1) begin n_fail++; $display("FAIL mret_mie got %0b want 1", mstatus_mie); end
        n_checks++; if (mstatus_mpie !== 1'b1) begin n_fail++; $display("FAIL mret_mpie got %0b want 1", mstatus_mpie); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mret_busy_end got %0b want 0", busy); end
    endtask

    // ext+tm pending, all enabled: ext wins, cause 0x8000000B.
    task automatic test_irq;
        logic [31:0] exp_addr;
`ifdef TRAP_VECTORED_EN
        exp_addr = 32'h0000_802C;
`else
        exp_addr = 32'h0000_8000;
`endif
        mtvec = 32'h0000_8001; mie_bits = 3'b111; irq_ext = 1; irq_tm = 1; pc = 32'h300;
        tick();
        insn_valid = 1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL irq_accept_busy got %0b want 1", busy); end
        tick();
        insn_valid = 0; irq_ext = 0; irq_tm = 0; pc = 32'h0;
        n_checks++; if (csr_we !== 1'b1 || csr_waddr !== 12'h341 || csr_wdata !== 32'h300) begin n_fail++; $display("FAIL irq_epc got we=%0b %h=%h want we=1 341=00000300", csr_we, csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (csr_we !== 1'b1 || csr_waddr !== 12'h342 || csr_wdata !== 32'h8000_000B) begin n_fail++; $display("FAIL irq_cause got we=%0b %h=%h want we=1 342=8000000b", csr_we, csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (csr_we !== 1'b1 || csr_waddr !== 12'h343 || csr_wdata !== 32'h0) begin n_fail++; $display("FAIL irq_tval got we=%0b %h=%h want we=1 343=00000000", csr_we, csr_waddr, csr_wdata); end
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL irq_trap_early got %0b want 0", trap); end
        tick();
        n_checks++; if (trap !== 1'b1 || csr_we !== 1'b0) begin n_fail++; $display("FAIL irq_jump got trap=%0b we=%0b want trap=1 we=0", trap, csr_we); end
        n_checks++; if (address !== exp_addr) begin n_fail++; $display("FAIL irq_address got %h want %h", address, exp_addr); end
        tick();
        n_checks++; if (mstatus_mie !== 1'b0 || mstatus_mpie !== 1'b1) begin n_fail++; $display("FAIL irq_mstatus got mie=%0b mpie=%0b want mie=0 mpie=1", mstatus_mie, mstatus_mpie); end
        n_checks++; if (trap !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL irq_idle got trap=%0b busy=%0b want 0 0", trap, busy); end
        clear_inputs();
    endtask

    // ecall with mret in the same cycle, then ebreak back-to-back after JUMP.
    task automatic test_back_to_back;
        mtvec = 32'h0000_9000; pc = 32'h400; exc_ecall = 1; mret = 1; mepc = 32'h700; insn_valid = 1;
        tick();
        clear_inputs(); mtvec = 32'h0000_9000;
        n_checks++; if (csr_waddr !== 12'h341 || csr_wdata !== 32'h400) begin n_fail++; $display("FAIL ecall_epc got %h=%h want 341=00000400", csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (csr_waddr !== 12'h342 || csr_wdata !== 32'd11) begin n_fail++; $display("FAIL ecall_cause got %h=%h want 342=0000000b", csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (csr_wdata !== 32'h0) begin n_fail++; $display("FAIL ecall_tval got %h want 0", csr_wdata); end
        tick();
        n_checks++; if (trap !== 1'b1 || address !== 32'h9000) begin n_fail++; $display("FAIL ecall_jump got trap=%0b addr=%h want 1 00009000", trap, address); end
        // Request presented during JUMP; taken only once IDLE is reached.
        pc = 32'h500; exc_ebreak = 1; insn_valid = 1;
        tick();
        #1;
        n_checks++; if (trap !== 1'b0 || busy !== 1'b1 || csr_we !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got trap=%0b busy=%0b we=%0b want 0 1 0", trap, busy, csr_we); end
        n_checks++; if (mstatus_mie !== 1'b0 || mstatus_mpie !== 1'b0) begin n_fail++; $display("FAIL ecall_mstatus got mie=%0b mpie=%0b want 0 0", mstatus_mie, mstatus_mpie); end
        tick();
        clear_inputs(); mtvec = 32'h0000_9000;
        n_checks++; if (csr_waddr !== 12'h341 || csr_wdata !== 32'h500) begin n_fail++; $display("FAIL b2b_epc got %h=%h want 341=00000500", csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (csr_wdata !== 32'd3) begin n_fail++; $display("FAIL b2b_cause got %h want 00000003", csr_wdata); end
        tick();
        n_checks++; if (csr_wdata !== 32'h500) begin n_fail++; $display("FAIL b2b_tval got %h want 00000500", csr_wdata); end
        tick();
        n_checks++; if (trap !== 1'b1 || address !== 32'h9000) begin n_fail++; $display("FAIL b2b_jump got trap=%0b addr=%h want 1 00009000", trap, address); end
        tick();
        clear_inputs();
    endtask

    // MIE is 0 here, so a pending enabled timer interrupt must not trap.
    task automatic test_irq_masked;
        mie_bits = 3'b111; irq_tm = 1; mtvec = 32'h8000;
        tick();
        insn_valid = 1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL masked_busy got %0b want 0", busy); end
        tick(); tick();
        n_checks++; if (trap !== 1'b0 || csr_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL masked_idle got trap=%0b we=%0b busy=%0b want 0 0 0", trap, csr_we, busy); end
        clear_inputs();
        tick();
    endtask

    // Illegal (with ebreak also raised) wins; latency of four cycles to trap.
    task automatic test_illegal;
        pc = 32'h100; exc_illegal = 1; exc_ebreak = 1; insn_word = 32'hFFFF_FFFF; mtvec = 32'h8000; insn_valid = 1;
        tick();
        clear_inputs(); mtvec = 32'h8000;
        n_checks++; if (csr_we !== 1'b1 || csr_waddr !== 12'h341 || csr_wdata !== 32'h100) begin n_fail++; $display("FAIL ill_epc got we=%0b %h=%h want 1 341=00000100", csr_we, csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (csr_waddr !== 12'h342 || csr_wdata !== 32'd2) begin n_fail++; $display("FAIL ill_cause got %h=%h want 342=00000002", csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (csr_waddr !== 12'h343 || csr_wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ill_tval got %h=%h want 343=ffffffff", csr_waddr, csr_wdata); end
        tick();
        n_checks++; if (trap !== 1'b1 || address !== 32'h8000) begin n_fail++; $display("FAIL ill_jump got trap=%0b addr=%h want 1 00008000", trap, address); end
        tick();
    endtask

    // Misaligned with vectored mtvec: exceptions always use the base.
    task automatic test_misalign;
        pc = 32'h120; exc_misalign = 1; bad_addr = 32'h1233; mtvec = 32'h8001; insn_valid = 1;
        tick();
        clear_inputs();
        tick();
        n_checks++; if (csr_wdata !== 32'd4) begin n_fail++; $display("FAIL mis_cause got %h want 00000004", csr_wdata); end
        tick();
        n_checks++; if (csr_wdata !== 32'h1233) begin n_fail++; $display("FAIL mis_tval got %h want 00001233", csr_wdata); end
        tick();
        n_checks++; if (trap !== 1'b1 || address !== 32'h8000) begin n_fail++; $display("FAIL mis_jump got trap=%0b addr=%h want 1 00008000", trap, address); end
        tick();
    endtask

    // Reset during the mcause write aborts without a redirect pulse.
    task automatic test_rst_mid;
        pc = 32'h140; exc_ecall = 1; mtvec = 32'h8000; insn_valid = 1;
        tick();
        clear_inputs();
        tick();
        n_checks++; if (csr_waddr !== 12'h342) begin n_fail++; $display("FAIL rstmid_in_cause got %h want 342", csr_waddr); end
        rst = 1;
        tick();
        n_checks++; if (busy !== 1'b0 || trap !== 1'b0 || csr_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort got busy=%0b trap=%0b we=%0b want 0 0 0", busy, trap, csr_we); end
        n_checks++; if (mstatus_mie !== 1'b0 || mstatus_mpie !== 1'b1) begin n_fail++; $display("FAIL rstmid_mstatus got mie=%0b mpie=%0b want 0 1", mstatus_mie, mstatus_mpie); end
        rst = 0;
        tick(); tick(); tick();
        n_checks++; if (trap !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got trap=%0b busy=%0b want 0 0", trap, busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1;
        clear_inputs();
        test_reset();
        test_mret();
        test_irq();
        test_back_to_back();
        test_irq_masked();
        test_illegal();
        test_misalign();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
